// File: rtl/bcd_updown_scan_counter.sv
// bcd_updown_scan_counter: debounced two-button BCD up/down counter with multiplexed 7-segment scan.
module bcd_updown_scan_counter #(
  parameter int DIGITS   = 2,
  parameter int DEB_DIV  = 1000000,
  parameter int DEB_LEN  = 3,
  parameter int SCAN_DIV = 10000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_up_i,
  input  logic                  btn_dn_i,
  input  logic                  clr_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  wrap_o,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     an_o
);
  localparam int DW = DEB_DIV > 1 ? $clog2(DEB_DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

  logic [1:0]               sync1_q, sync2_q;
  logic [DW-1:0]            div_q, div_d;
  logic [1:0][DEB_LEN-1:0]  hist_q, hist_d;
  logic [1:0]               lvl_q, lvl_d, dly_q;
  logic [4*DIGITS-1:0]      bcd_q, bcd_d, inc, dec;
  logic                     wrap_q, wrap_d;
  logic [SW-1:0]            scan_q, scan_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic [7:0]               seg_q, seg_d;
  logic                     tick, scan_tc, all9, all0, up, dn;
  logic [1:0]               press;
  logic [3:0]               sel;

  always_comb begin
    tick    = div_q == DW'(DEB_DIV - 1);
    div_d   = tick ? '0 : div_q + 1'b1;
    hist_d  = hist_q;
    lvl_d   = lvl_q;
    for (int b = 0; b < 2; b++) begin
      hist_d[b] = tick ? {hist_q[b][DEB_LEN-2:0], sync2_q[b]} : hist_q[b];
      lvl_d[b]  = &hist_q[b] ? 1'b1 : ~|hist_q[b] ? 1'b0 : lvl_q[b];
    end
    press = lvl_q & ~dly_q;
    up    = press[0];
    dn    = press[1];
    // ripple carry/borrow: a digit only moves when every lower digit wrapped
    inc  = bcd_q;
    dec  = bcd_q;
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i+:4] = !all9 ? bcd_q[4*i+:4] : bcd_q[4*i+:4] == 4'd9 ? 4'd0 : bcd_q[4*i+:4] + 4'd1;
      dec[4*i+:4] = !all0 ? bcd_q[4*i+:4] : bcd_q[4*i+:4] == 4'd0 ? 4'd9 : bcd_q[4*i+:4] - 4'd1;
      all9 = all9 & (bcd_q[4*i+:4] == 4'd9);
      all0 = all0 & (bcd_q[4*i+:4] == 4'd0);
    end
    bcd_d   = clr_i ? '0 : (up & dn) ? bcd_q : up ? inc : dn ? dec : bcd_q;
    wrap_d  = !clr_i && (up ^ dn) && (up ? all9 : all0);
    scan_tc = scan_q == SW'(SCAN_DIV - 1);
    scan_d  = scan_tc ? '0 : scan_q + 1'b1;
    idx_d   = !scan_tc ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    an_d    = DIGITS'(1) << idx_d;
    sel     = '0;
    for (int i = 0; i < DIGITS; i++)
      if (IW'(i) == idx_d) sel = bcd_d[4*i+:4];
    case (sel)
      4'd1:    seg_d = 8'h60;
      4'd2:    seg_d = 8'hDA;
      4'd3:    seg_d = 8'hF2;
      4'd4:    seg_d = 8'h66;
      4'd5:    seg_d = 8'hB6;
      4'd6:    seg_d = 8'hBE;
      4'd7:    seg_d = 8'hE0;
      4'd8:    seg_d = 8'hFE;
      4'd9:    seg_d = 8'hF6;
      default: seg_d = 8'hFC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      hist_q  <= '0;
      lvl_q   <= '0;
      dly_q   <= '0;
      bcd_q   <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      an_q    <= DIGITS'(1);
      seg_q   <= 8'hFC;
    end else begin
      sync1_q <= {btn_dn_i, btn_up_i};
      sync2_q <= sync1_q;
      div_q   <= div_d;
      hist_q  <= hist_d;
      lvl_q   <= lvl_d;
      dly_q   <= lvl_q;
      bcd_q   <= bcd_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end

  assign bcd_o  = bcd_q;
  assign wrap_o = wrap_q;
  assign an_o   = an_q;
  assign seg_o  = seg_q;
endmodule

// File: tb/tb_bcd_updown_scan_counter.sv
// tb_bcd_updown_scan_counter: random button/clear sequences checked against an integer count model.
module tb_bcd_updown_scan_counter;
  logic       clk = 1'b0, rst_n = 1'b0, btn_up = 1'b0, btn_dn = 1'b0, clr = 1'b0;
  logic [7:0] bcd, seg;
  logic       wrap;
  logic [1:0] an;
  int n_chk = 0, n_fail = 0, n_edge = 0, changes = 0, wraps = 0, cnt = 0, dsel;
  int c0, w0;
  logic [7:0] prev = 8'h00;
  localparam logic [7:0] SEG_TAB [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  bcd_updown_scan_counter #(.DIGITS(2), .DEB_DIV(4), .DEB_LEN(3), .SCAN_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up_i(btn_up), .btn_dn_i(btn_dn), .clr_i(clr),
    .bcd_o(bcd), .wrap_o(wrap), .seg_o(seg), .an_o(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) n_edge <= 0;
    else n_edge <= n_edge + 1;

  // scan position follows elapsed clocks since reset; segments always show the selected digit
  always @(negedge clk)
    if (rst_n) begin
      dsel = (an == 2'b10) ? int'(bcd[7:4]) : int'(bcd[3:0]);
      chk("scan_an", an, 1 << ((n_edge / 8) % 2));
      chk("scan_seg", seg, dsel <= 9 ? SEG_TAB[dsel] : 8'h00);
      chk("digit_range", (bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9), 1);
      if (bcd !== prev) changes++;
      if (wrap) wraps++;
      prev = bcd;
    end else prev = bcd;

  task automatic op(input bit u, input bit d, input bit bnc, input bit c, input string tag);
    int ec, ew, pc, pw;
    pc = changes;
    pw = wraps;
    if (bnc)
      for (int i = 0; i < 20; i++) begin
        btn_up = ~btn_up;
        repeat (3) @(negedge clk);
      end
    btn_up = u;
    btn_dn = d;
    clr    = c;
    repeat (40) @(negedge clk);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    clr    = 1'b0;
    repeat (40) @(negedge clk);
    ec = 1;
    ew = 0;
    if (c) begin
      ec  = int'(cnt != 0);
      cnt = 0;
    end else if (u && d) ec = 0;
    else if (u) begin
      ew  = int'(cnt == 99);
      cnt = (cnt + 1) % 100;
    end else begin
      ew  = int'(cnt == 0);
      cnt = (cnt + 99) % 100;
    end
    chk({tag, "_bcd"}, bcd, to_bcd(cnt));
    chk({tag, "_changes"}, changes - pc, ec);
    chk({tag, "_wraps"}, wraps - pw, ew);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd, 0);
    chk("rst_an", an, 1);
    chk("rst_seg", seg, 8'hFC);
    chk("rst_wrap", wrap, 0);
    #2 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_bcd", bcd, 0);
    chk("idle_changes", changes, 0);
    chk("idle_wraps", wraps, 0);
    for (int i = 0; i < 10; i++) op(1, 0, 0, 0, "up_seq");
    op(0, 0, 0, 1, "clr");
    op(0, 1, 0, 0, "dn_wrap");
    op(1, 0, 0, 0, "up_wrap");
    op(0, 1, 0, 0, "dn_wrap2");
    op(1, 0, 1, 0, "bounce");
    op(1, 1, 0, 0, "both");
    op(1, 0, 0, 1, "clr_press");
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op(1, 0, 0, 0, "rnd_up");
        4, 5, 6:    op(0, 1, 0, 0, "rnd_dn");
        7:          op(1, 1, 0, 0, "rnd_both");
        8:          op($urandom_range(0, 1) == 1, 0, 0, 1, "rnd_clr");
        default:    op(1, 0, 1, 0, "rnd_bounce");
      endcase
    end
    op(0, 0, 0, 1, "pre_clr");
    while (cnt != 42) op(1, 0, 0, 0, "preload");
    repeat ($urandom_range(1, 20)) @(negedge clk);
    btn_up = 1'b1;
    repeat (8) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_bcd", bcd, 0);
    chk("arst_an", an, 1);
    chk("arst_seg", seg, 8'hFC);
    chk("arst_wrap", wrap, 0);
    repeat (5) @(negedge clk);
    btn_up = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    c0 = changes;
    w0 = wraps;
    repeat (60) @(negedge clk);
    chk("post_rst_bcd", bcd, 0);
    chk("post_rst_changes", changes - c0, 0);
    chk("post_rst_wraps", wraps - w0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
